// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide
// over operand magnitudes, one operation in flight, valid/ready on both sides.
module muldiv_unit #(
  parameter int XLEN      = 32,
  parameter int TAG_WIDTH = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           funct3,
  input  logic [XLEN-1:0]      rs1_data,
  input  logic [XLEN-1:0]      rs2_data,
  input  logic [TAG_WIDTH-1:0] rd_address_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      rd_data,
  output logic [TAG_WIDTH-1:0] rd_address_out,
  output logic                 busy
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST_ITER = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                 r_state;
  state_t                 w_stateNext;
  logic [CW-1:0]          r_count;
  logic [2:0]             r_op;
  logic [XLEN-1:0]        r_hi;
  logic [XLEN-1:0]        r_lo;
  logic [XLEN-1:0]        r_b;
  logic                   r_negA;
  logic                   r_negB;
  logic [XLEN-1:0]        r_result;
  logic [TAG_WIDTH-1:0]   r_tag;

  logic                   w_accept;
  logic                   w_signedA;
  logic                   w_signedB;
  logic                   w_negA;
  logic                   w_negB;
  logic [XLEN-1:0]        w_magA;
  logic [XLEN-1:0]        w_magB;
  logic                   w_divZero;
  logic                   w_overflow;
  logic                   w_fast;
  logic [XLEN-1:0]        w_fastResult;

  logic [XLEN:0]          w_mulSum;
  logic [XLEN:0]          w_divShift;
  logic [XLEN:0]          w_divDiff;
  logic                   w_divGe;
  logic [XLEN-1:0]        w_iterHi;
  logic [XLEN-1:0]        w_iterLo;
  logic [2*XLEN-1:0]      w_prod;
  logic [2*XLEN-1:0]      w_prodSigned;
  logic [XLEN-1:0]        w_quot;
  logic [XLEN-1:0]        w_rem;
  logic [XLEN-1:0]        w_final;

  assign in_ready       = (r_state == IDLE);
  assign out_valid      = (r_state == DONE);
  assign busy           = (r_state != IDLE);
  assign rd_data        = r_result;
  assign rd_address_out = r_tag;

  // Operand decode at accept: signed treatment, magnitudes and the single-cycle special cases.
  always_comb begin
    w_accept     = in_valid & in_ready & ~flush;
    w_signedA    = (funct3 == 3'b001) | (funct3 == 3'b010) | (funct3 == 3'b100) | (funct3 == 3'b110);
    w_signedB    = (funct3 == 3'b001) | (funct3 == 3'b100) | (funct3 == 3'b110);
    w_negA       = w_signedA & rs1_data[XLEN-1];
    w_negB       = w_signedB & rs2_data[XLEN-1];
    w_magA       = w_negA ? -rs1_data : rs1_data;
    w_magB       = w_negB ? -rs2_data : rs2_data;
    w_divZero    = (rs2_data == '0);
    w_overflow   = ~funct3[0] & (rs1_data == MIN_NEG) & (rs2_data == '1);
    w_fast       = funct3[2] & (w_divZero | w_overflow);
    w_fastResult = '0;
    if (w_divZero)
      w_fastResult = funct3[1] ? rs1_data : '1;
    else if (w_overflow)
      w_fastResult = funct3[1] ? '0 : MIN_NEG;
  end

  // One iteration step; r_hi/r_lo are product halves for multiply, remainder/quotient for divide.
  always_comb begin
    w_mulSum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    w_divShift = {r_hi, r_lo[XLEN-1]};
    w_divDiff  = w_divShift - {1'b0, r_b};
    w_divGe    = ~w_divDiff[XLEN];
    if (r_op[2]) begin
      w_iterHi = w_divGe ? w_divDiff[XLEN-1:0] : w_divShift[XLEN-1:0];
      w_iterLo = {r_lo[XLEN-2:0], w_divGe};
    end else begin
      w_iterHi = w_mulSum[XLEN:1];
      w_iterLo = {w_mulSum[0], r_lo[XLEN-1:1]};
    end
    w_prod       = {w_iterHi, w_iterLo};
    w_prodSigned = (r_negA ^ r_negB) ? -w_prod : w_prod;
    w_quot       = (r_negA ^ r_negB) ? -w_iterLo : w_iterLo;
    w_rem        = r_negA ? -w_iterHi : w_iterHi;
    case (r_op)
      3'b000:                   w_final = w_prodSigned[XLEN-1:0];
      3'b001, 3'b010, 3'b011:   w_final = w_prodSigned[2*XLEN-1:XLEN];
      3'b100, 3'b101:           w_final = w_quot;
      default:                  w_final = w_rem;
    endcase
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE: if (w_accept) w_stateNext = w_fast ? DONE : BUSY;
      BUSY: if (r_count == LAST_ITER) w_stateNext = DONE;
      DONE: if (out_ready) w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
    if (flush) w_stateNext = IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_stateNext;
  end

  // Flush clears the datapath exactly like reset so a discarded result never leaks out.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      r_count  <= '0;
      r_op     <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_negA   <= 1'b0;
      r_negB   <= 1'b0;
      r_result <= '0;
      r_tag    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op    <= funct3;
            r_hi    <= '0;
            r_lo    <= w_magA;
            r_b     <= w_magB;
            r_negA  <= w_negA;
            r_negB  <= w_negB;
            r_count <= '0;
            r_tag   <= rd_address_in;
            if (w_fast) r_result <= w_fastResult;
          end
        end
        BUSY: begin
          r_hi    <= w_iterHi;
          r_lo    <= w_iterLo;
          r_count <= r_count + 1'b1;
          if (r_count == LAST_ITER) r_result <= w_final;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: normal ops, fast paths,
// backpressure and abort by flush/reset, with hand-computed expectations.
module tb_muldiv_unit;

  logic        clock;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  funct3;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rd_address_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] rd_data;
  logic [4:0]  rd_address_out;
  logic        busy;

  int checkCount = 0;
  int passCount  = 0;

  muldiv_unit #(.XLEN(32), .TAG_WIDTH(5)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_address_in(rd_address_in),
    .out_valid(out_valid), .out_ready(out_ready), .rd_data(rd_data),
    .rd_address_out(rd_address_out), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
  endtask

  // Issue one request, wait for its result and complete the handshake with out_ready=1.
  task automatic applyStimulus(input string name, input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] tag,
                               input logic [31:0] expected, input int expLatency);
    int latency;
    @(negedge clock);
    checkOutput({name, " in_ready"}, {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; funct3 = op; rs1_data = a; rs2_data = b; rd_address_in = tag; out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0; rs1_data = 32'hDEADBEEF; rs2_data = 32'h0BADF00D; rd_address_in = 5'd31;
    checkOutput({name, " busy"}, {31'b0, busy}, 32'd1);
    latency = 1;
    while (!out_valid && latency < 100) begin
      @(negedge clock);
      latency++;
    end
    checkOutput({name, " latency"}, latency, expLatency);
    checkOutput({name, " rd_data"}, rd_data, expected);
    checkOutput({name, " rd_address_out"}, {27'b0, rd_address_out}, {27'b0, tag});
    @(negedge clock);
    checkOutput({name, " out_valid drop"}, {31'b0, out_valid}, 32'd0);
    checkOutput({name, " in_ready back"}, {31'b0, in_ready}, 32'd1);
  endtask

  task automatic watchNoResult(input string name);
    int rises;
    rises = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (out_valid) rises++;
    end
    checkOutput({name, " no result"}, rises, 32'd0);
  endtask

  initial begin
    int latency;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; funct3 = 3'b000;
    rs1_data = '0; rs2_data = '0; rd_address_in = '0; out_ready = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    checkOutput("reset in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("reset out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset busy", {31'b0, busy}, 32'd0);
    checkOutput("reset rd_data", rd_data, 32'd0);
    checkOutput("reset rd_address_out", {27'b0, rd_address_out}, 32'd0);

    applyStimulus("MUL neg", 3'b000, 32'd7, 32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB, 33);
    applyStimulus("MULH min", 3'b001, 32'h80000000, 32'h80000000, 5'd1, 32'h40000000, 33);
    applyStimulus("MULHU max", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'hFFFFFFFE, 33);
    applyStimulus("MULHSU max", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'hFFFFFFFF, 33);
    applyStimulus("MULHU carry", 3'b011, 32'h00010000, 32'h00010000, 5'd4, 32'h00000001, 33);
    applyStimulus("MUL x0 tag", 3'b000, 32'h12345678, 32'd16, 5'd0, 32'h23456780, 33);
    applyStimulus("DIV neg", 3'b100, 32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFD, 33);
    applyStimulus("REM neg", 3'b110, 32'hFFFFFFF9, 32'd2, 5'd7, 32'hFFFFFFFF, 33);
    applyStimulus("DIVU", 3'b101, 32'hFFFFFFF9, 32'd2, 5'd8, 32'h7FFFFFFC, 33);
    applyStimulus("REMU", 3'b111, 32'hFFFFFFF9, 32'd2, 5'd9, 32'h00000001, 33);
    applyStimulus("DIV div0", 3'b100, 32'd5, 32'd0, 5'd10, 32'hFFFFFFFF, 1);
    applyStimulus("REMU div0", 3'b111, 32'd5, 32'd0, 5'd11, 32'h00000005, 1);
    applyStimulus("DIV ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h80000000, 1);
    applyStimulus("REM ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h00000000, 1);

    // Backpressure: result of 6*7 held while a DIVU 100/7 request waits.
    @(negedge clock);
    in_valid = 1'b1; funct3 = 3'b000; rs1_data = 32'd6; rs2_data = 32'd7; rd_address_in = 5'd3; out_ready = 1'b0;
    @(posedge clock);
    @(negedge clock);
    funct3 = 3'b101; rs1_data = 32'd100; rs2_data = 32'd7; rd_address_in = 5'd9;
    latency = 1;
    while (!out_valid && latency < 100) begin
      @(negedge clock);
      latency++;
    end
    checkOutput("bp latency", latency, 32'd33);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      checkOutput("bp out_valid", {31'b0, out_valid}, 32'd1);
      checkOutput("bp rd_data", rd_data, 32'd42);
      checkOutput("bp rd_address_out", {27'b0, rd_address_out}, 32'd3);
      checkOutput("bp in_ready", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clock);
    checkOutput("bp idle out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("bp idle in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    checkOutput("bp held accept busy", {31'b0, busy}, 32'd1);
    latency = 1;
    while (!out_valid && latency < 100) begin
      @(negedge clock);
      latency++;
    end
    checkOutput("bp second latency", latency, 32'd33);
    checkOutput("bp second rd_data", rd_data, 32'd14);
    checkOutput("bp second rd_address_out", {27'b0, rd_address_out}, 32'd9);
    @(negedge clock);

    // Flush in the middle of an operation (iteration counter at 15).
    in_valid = 1'b1; funct3 = 3'b000; rs1_data = 32'd3; rs2_data = 32'd4; rd_address_in = 5'd17;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    repeat (15) @(negedge clock);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    checkOutput("flush in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("flush out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("flush busy", {31'b0, busy}, 32'd0);
    watchNoResult("flush");

    applyStimulus("post-flush MULHU", 3'b011, 32'hFFFFFFFF, 32'd2, 5'd20, 32'h00000001, 33);

    // Reset in the middle of an operation; the last result must also be cleared.
    @(negedge clock);
    in_valid = 1'b1; funct3 = 3'b100; rs1_data = 32'd1000; rs2_data = 32'd3; rd_address_in = 5'd21;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    repeat (15) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checkOutput("reset abort in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("reset abort out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset abort rd_data", rd_data, 32'd0);
    checkOutput("reset abort rd_address_out", {27'b0, rd_address_out}, 32'd0);
    watchNoResult("reset abort");

    // Flush on the accept edge cancels the request.
    @(negedge clock);
    in_valid = 1'b1; flush = 1'b1; funct3 = 3'b101; rs1_data = 32'd9; rs2_data = 32'd0; rd_address_in = 5'd22;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0; flush = 1'b0;
    checkOutput("flush accept busy", {31'b0, busy}, 32'd0);
    checkOutput("flush accept in_ready", {31'b0, in_ready}, 32'd1);
    watchNoResult("flush accept");

    applyStimulus("final DIV", 3'b100, 32'd100, 32'hFFFFFFF9, 5'd23, 32'hFFFFFFF2, 33);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
